multiplier_request_sequencer: RTL and testbench

//  Initiator side of the multiplier sta/done_sig interface. It reads up to DEPTH operand pairs from an

---
 rtl/multiplier_request_sequencer_pkg.sv | 14 +
 rtl/mult_seq_tracker.sv | 75 +++++++
 rtl/multiplier_request_sequencer.sv | 136 +++++++++++++
 tb/tb_multiplier_request_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/multiplier_request_sequencer_pkg.sv
// Shared constants and FSM state encoding for the multiplier request sequencer.
package multiplier_request_sequencer_pkg;

    localparam int EXTENDED_SINGLE = 64;
    localparam int MULT_LATENCY    = 5;

    typedef enum logic [1:0] {
        MSEQ_IDLE  = 2'd0,
        MSEQ_ISSUE = 2'd1,
        MSEQ_DRAIN = 2'd2,
        MSEQ_DONE  = 2'd3
    } mseq_state_t;

endpackage

// File: rtl/mult_seq_tracker.sv
// Outstanding/completion bookkeeping for the multiplier sequencer, plus the
// optional DRAIN watchdog enabled by MULT_SEQ_TIMEOUT_EN.
module mult_seq_tracker
    import multiplier_request_sequencer_pkg::*;
#(
    parameter int MUL_LATENCY = MULT_LATENCY,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             issue,
    input  logic             mul_done,
`ifdef MULT_SEQ_TIMEOUT_EN
    input  logic             in_drain,
    output logic             timeout,
`endif
    output logic [CNT_W-1:0] comp_cnt,
    output logic             done_ok,
    output logic             done_err
);

    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_nxt;

    // A done with nothing in flight is a protocol error and is never written back.
    assign done_ok  = mul_done && (outstanding != '0);
    assign done_err = mul_done && (outstanding == '0);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        outstanding_nxt = outstanding;
        if (issue && !done_ok)
            outstanding_nxt = outstanding + 1'b1;
        else if (done_ok && !issue)
            outstanding_nxt = outstanding - 1'b1;
`ifdef MULT_SEQ_TIMEOUT_EN
        if (timeout)
            outstanding_nxt = '0;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding <= '0;
            comp_cnt    <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (clear)
                comp_cnt <= '0;
            else if (done_ok)
                comp_cnt <= comp_cnt + 1'b1;
        end
    end

`ifdef MULT_SEQ_TIMEOUT_EN
    localparam int WD_LIMIT = MUL_LATENCY + 4;
    localparam int WD_W     = $clog2(WD_LIMIT + 1);

    logic [WD_W-1:0] wd_cnt;

    // wd_cnt holds the idle DRAIN cycles seen before this one.
    assign timeout = in_drain && !mul_done && (wd_cnt == WD_W'(WD_LIMIT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            wd_cnt <= '0;
        else if (!in_drain || mul_done)
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + 1'b1;
    end
`endif

endmodule

// File: rtl/multiplier_request_sequencer.sv
// Issues operand pairs to the pipelined multiplier and writes products back in order.
// Optional DRAIN watchdog: define MULT_SEQ_TIMEOUT_EN.
module multiplier_request_sequencer
    import multiplier_request_sequencer_pkg::*;
#(
    parameter int DATA_W      = EXTENDED_SINGLE,
    parameter int MUL_LATENCY = MULT_LATENCY,
    parameter int DEPTH       = 8,
    parameter int CNT_W       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    output logic [CNT_W-1:0]  op_rd_addr,
    input  logic [DATA_W-1:0] op_x,
    input  logic [DATA_W-1:0] op_y,
    output logic              mul_sta,
    output logic [DATA_W-1:0] mul_x,
    output logic [DATA_W-1:0] mul_y,
    input  logic [DATA_W-1:0] mul_xy,
    input  logic              mul_done,
    output logic              res_we,
    output logic [CNT_W-1:0]  res_addr,
    output logic [DATA_W-1:0] res_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    mseq_state_t      state;
    logic [CNT_W-1:0] len_q;
    logic             rd_valid;
    logic             accept;
    logic [CNT_W-1:0] comp_cnt;
    logic             done_ok;
    logic             done_err;
    logic             timeout;

    assign accept = (state == MSEQ_IDLE) && start;

    mult_seq_tracker #(
        .MUL_LATENCY (MUL_LATENCY),
        .CNT_W       (CNT_W)
    ) u_tracker (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .issue    (mul_sta),
        .mul_done (mul_done),
`ifdef MULT_SEQ_TIMEOUT_EN
        .in_drain (state == MSEQ_DRAIN),
        .timeout  (timeout),
`endif
        .comp_cnt (comp_cnt),
        .done_ok  (done_ok),
        .done_err (done_err)
    );

`ifndef MULT_SEQ_TIMEOUT_EN
    assign timeout = 1'b0;
`endif

    // NOTE: state is assigned with <= only, so every reader sees the pre-edge value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the datapath registers are reset too because they are visible outputs.
            state      <= MSEQ_IDLE;
            len_q      <= '0;
            op_rd_addr <= '0;
            rd_valid   <= 1'b0;
            mul_sta    <= 1'b0;
            mul_x      <= '0;
            mul_y      <= '0;
            res_we     <= 1'b0;
            res_addr   <= '0;
            res_data   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;
            case (state)
                MSEQ_IDLE: begin
                    if (start) begin
                        len_q      <= (len > DEPTH_C) ? DEPTH_C : len;
                        op_rd_addr <= '0;
                        if (len == '0) begin
                            state <= MSEQ_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= MSEQ_ISSUE;
                            busy  <= 1'b1;
                        end
                    end
                end
                MSEQ_ISSUE: begin
                    rd_valid <= 1'b1;
                    if (op_rd_addr == len_q - 1'b1)
                        state <= MSEQ_DRAIN;
                    else
                        op_rd_addr <= op_rd_addr + 1'b1;
                end
                MSEQ_DRAIN: begin
                    if (comp_cnt == len_q || timeout) begin
                        state      <= MSEQ_DONE;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        op_rd_addr <= '0;
                    end
                end
                MSEQ_DONE: state <= MSEQ_IDLE;
                default:   state <= MSEQ_IDLE;
            endcase

            // Operands arrive one cycle after their address, so the request trails rd_valid.
            mul_sta <= rd_valid;
            if (rd_valid) begin
                mul_x <= op_x;
                mul_y <= op_y;
            end

            res_we <= done_ok;
            if (done_ok) begin
                res_addr <= comp_cnt;
                res_data <= mul_xy;
            end

            err <= accept ? (len > DEPTH_C) : (err | done_err | timeout);
        end
    end

endmodule

// File: tb/tb_multiplier_request_sequencer.sv
// Directed bench: model operand store and 5-cycle multiplier around the sequencer.
module tb_multiplier_request_sequencer;

    localparam int L = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  len = '0;
    logic [3:0]  op_rd_addr;
    logic [63:0] op_x = '0;
    logic [63:0] op_y = '0;
    logic        mul_sta;
    logic [63:0] mul_x, mul_y, mul_xy;
    logic        mul_done;
    logic        res_we;
    logic [3:0]  res_addr;
    logic [63:0] res_data;
    logic        busy, done, err;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] x_mem [16];
    logic [63:0] y_mem [16];
    logic [63:0] p_exp [8];

    always #5 clk = ~clk;

    multiplier_request_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .op_rd_addr (op_rd_addr),
        .op_x       (op_x),
        .op_y       (op_y),
        .mul_sta    (mul_sta),
        .mul_x      (mul_x),
        .mul_y      (mul_y),
        .mul_xy     (mul_xy),
        .mul_done   (mul_done),
        .res_we     (res_we),
        .res_addr   (res_addr),
        .res_data   (res_data),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // Operand store with one-cycle registered read.
    always @(posedge clk) begin
        op_x <= x_mem[op_rd_addr];
        op_y <= y_mem[op_rd_addr];
    end

    // Multiplier model: done L cycles after sta; it is not reset with the DUT.
    logic [L-1:0] pv = '0;
    logic [63:0]  pp [L];
    int           sta_count = 0;
    int           drop_sel = -1;

    always @(posedge clk) begin
        for (int k = L - 1; k > 0; k--) begin
            pv[k] <= pv[k-1];
            pp[k] <= pp[k-1];
        end
        pv[0] <= mul_sta && (sta_count != drop_sel);
        pp[0] <= $realtobits($bitstoreal(mul_x) * $bitstoreal(mul_y));
        if (mul_sta) sta_count <= sta_count + 1;
    end

    assign mul_done = pv[L-1];
    assign mul_xy   = pp[L-1];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " mul_sta"},    64'(mul_sta),    64'd0);
        check({tag, " res_we"},     64'(res_we),     64'd0);
        check({tag, " busy"},       64'(busy),       64'd0);
        check({tag, " done"},       64'(done),       64'd0);
        check({tag, " err"},        64'(err),        64'd0);
        check({tag, " op_rd_addr"}, 64'(op_rd_addr), 64'd0);
        check({tag, " mul_x"},      mul_x,           64'd0);
        check({tag, " res_addr"},   64'(res_addr),   64'd0);
        check({tag, " res_data"},   res_data,        64'd0);
    endtask

    // One batch from start pulse; cycle c is sampled on the c-th falling edge after start.
    task automatic run_batch(input int blen, input int restart_at, input logic exp_err);
        int   n_eff, last;
        logic e_sta, e_we;
        n_eff = (blen > 8) ? 8 : blen;
        last  = (n_eff == 0) ? 1 : 4 + n_eff + L;
        @(negedge clk);
        start = 1'b1;
        len   = 4'(blen);
        for (int c = 1; c <= last + 2; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == restart_at) start = 1'b1;
            else if (c == restart_at + 1) start = 1'b0;
            e_sta = (c >= 3) && (c < 3 + n_eff);
            check($sformatf("len%0d c%0d mul_sta", blen, c), 64'(mul_sta), 64'(e_sta));
            if (e_sta) begin
                check($sformatf("len%0d c%0d mul_x", blen, c), mul_x, x_mem[c-3]);
                check($sformatf("len%0d c%0d mul_y", blen, c), mul_y, y_mem[c-3]);
            end
            e_we = (c >= 4 + L) && (c < 4 + L + n_eff);
            check($sformatf("len%0d c%0d res_we", blen, c), 64'(res_we), 64'(e_we));
            if (e_we) begin
                check($sformatf("len%0d c%0d res_addr", blen, c), 64'(res_addr), 64'(c - 4 - L));
                check($sformatf("len%0d c%0d res_data", blen, c), res_data, p_exp[c-4-L]);
            end
            check($sformatf("len%0d c%0d done", blen, c), 64'(done), 64'(c == last));
            check($sformatf("len%0d c%0d busy", blen, c), 64'(busy),
                  64'((n_eff > 0) && (c < last)));
            if (c <= n_eff)
                check($sformatf("len%0d c%0d op_rd_addr", blen, c), 64'(op_rd_addr), 64'(c - 1));
        end
        check($sformatf("len%0d err", blen), 64'(err), 64'(exp_err));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        x_mem[0] = $realtobits(1.5);   y_mem[0] = $realtobits(2.0);  p_exp[0] = $realtobits(3.0);
        x_mem[1] = $realtobits(2.5);   y_mem[1] = $realtobits(4.0);  p_exp[1] = $realtobits(10.0);
        x_mem[2] = $realtobits(-1.0);  y_mem[2] = $realtobits(3.0);  p_exp[2] = $realtobits(-3.0);
        x_mem[3] = $realtobits(0.5);   y_mem[3] = $realtobits(0.5);  p_exp[3] = $realtobits(0.25);
        x_mem[4] = $realtobits(3.0);   y_mem[4] = $realtobits(3.0);  p_exp[4] = $realtobits(9.0);
        x_mem[5] = $realtobits(1.25);  y_mem[5] = $realtobits(8.0);  p_exp[5] = $realtobits(10.0);
        x_mem[6] = $realtobits(-2.0);  y_mem[6] = $realtobits(-2.0); p_exp[6] = $realtobits(4.0);
        x_mem[7] = $realtobits(7.0);   y_mem[7] = $realtobits(0.5);  p_exp[7] = $realtobits(3.5);
        for (int i = 8; i < 16; i++) begin
            x_mem[i] = '0;
            y_mem[i] = '0;
        end

        // Reset state
        #2 rst = 1'b0;
        #20;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        run_batch(4, 0, 1'b0);
        run_batch(0, 0, 1'b0);
        run_batch(12, 0, 1'b1);
        run_batch(4, 5, 1'b0);

        // Reset in cycle 7 of a len=8 batch; the model keeps producing done pulses.
        @(negedge clk);
        start = 1'b1;
        len   = 4'd8;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("midreset");
        @(posedge clk);
        #1 rst = 1'b1;
        for (int c = 8; c <= 15; c++) begin
            @(negedge clk);
            check($sformatf("midreset c%0d res_we", c),  64'(res_we),  64'd0);
            check($sformatf("midreset c%0d mul_sta", c), 64'(mul_sta), 64'd0);
            check($sformatf("midreset c%0d busy", c),    64'(busy),    64'd0);
        end
        check("midreset stray done err", 64'(err), 64'd1);

`ifdef MULT_SEQ_TIMEOUT_EN
        // Second product is lost; watchdog aborts 9 cycles after the last write.
        drop_sel = sta_count + 1;
        @(negedge clk);
        start = 1'b1;
        len   = 4'd4;
        for (int c = 1; c <= 23; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            check($sformatf("wd c%0d res_we", c), 64'(res_we), 64'((c == 9) || (c == 11) || (c == 12)));
            if (c == 9)  check("wd res0", res_data, p_exp[0]);
            if (c == 11) begin
                check("wd addr1", 64'(res_addr), 64'd1);
                check("wd res1", res_data, p_exp[2]);
            end
            if (c == 12) begin
                check("wd addr2", 64'(res_addr), 64'd2);
                check("wd res2", res_data, p_exp[3]);
            end
            check($sformatf("wd c%0d done", c), 64'(done), 64'(c == 21));
            check($sformatf("wd c%0d busy", c), 64'(busy), 64'((c >= 1) && (c <= 20)));
            if (c == 21) check("wd err", 64'(err), 64'd1);
        end
        drop_sel = -1;
        run_batch(0, 0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
